// File: rtl/if_fetch_queue_if.sv
// Fetch-unit bus bundle: redirect, instruction-memory request/response and decode handshake.
interface if_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  // Fetch unit side
  modport master (
    input  redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc
  );

  // Environment side: memory, decoder and branch unit
  modport slave (
    output redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: sequential address generation, credit-limited
// memory requests, PC-tagged in-order instruction queue, redirect with flush.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  if_fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]      fetch_pc;
  entry_t           q_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop;
  logic [31:0]      pcq [DEPTH];
  logic [PTR_W-1:0] pcq_rd;
  logic [PTR_W-1:0] pcq_wr;

  logic             req_c;
  logic             accept_c;
  logic             rsp_c;
  logic             discard_c;
  logic             push_c;
  logic             pop_c;
  logic             head_valid_c;
  logic [CRD_W-1:0] credit_used_c;
  logic [31:0]      redir_target_c;

  // Credit rule: queued plus in-flight (stale included) never exceeds DEPTH,
  // so every accepted request has a guaranteed queue slot.
  always_comb begin
    credit_used_c  = CRD_W'(count) + CRD_W'(outstanding);
    req_c          = !reset && !bus.redirect && (credit_used_c < CRD_W'(DEPTH));
    accept_c       = req_c && bus.imem_ready;
    rsp_c          = bus.imem_rvalid && (outstanding != '0);
    discard_c      = rsp_c && (drop != '0);
    head_valid_c   = (count != '0);
    push_c         = rsp_c && (drop == '0) && !bus.redirect;
    pop_c          = head_valid_c && bus.id_ready && !bus.redirect;
    redir_target_c = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  // Control state: pointers, counters, fetch PC; redirect overrides push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      if (accept_c) pcq_wr <= pcq_wr + PTR_W'(1);
      if (rsp_c)    pcq_rd <= pcq_rd + PTR_W'(1);
      outstanding <= outstanding + CNT_W'(accept_c) - CNT_W'(rsp_c);
      if (bus.redirect) begin
        fetch_pc <= redir_target_c;
        drop     <= outstanding - CNT_W'(rsp_c);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept_c)  fetch_pc <= fetch_pc + 32'd4;
        if (discard_c) drop     <= drop - CNT_W'(1);
        if (push_c)    wr_ptr   <= wr_ptr + PTR_W'(1);
        if (pop_c)     rd_ptr   <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
      end
    end
  end

  // Storage for request tags and queued instructions; validity lives in the counters.
  always_ff @(posedge clk) begin
    if (accept_c) pcq[pcq_wr] <= fetch_pc;
    if (push_c)   q_mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: pcq[pcq_rd]};
  end

  // Outputs: request side is combinational, decode side reads registered state only.
  always_comb begin
    bus.imem_req  = req_c;
    bus.imem_addr = fetch_pc;
    bus.id_valid  = head_valid_c;
    bus.id_instr  = head_valid_c ? q_mem[rd_ptr].instr : NOP;
    bus.id_pc     = head_valid_c ? q_mem[rd_ptr].pc : 32'h0;
  end

endmodule
